sreg_target: RTL and testbench

//  IC-side responder for the pixel configuration shift-register interface (shift/sclk/serial/write_cfg/sreg[1:0]).

---
 rtl/sreg_pkg.sv | 36 +++
 rtl/sreg_sync.sv | 37 +++
 rtl/sreg_target.sv | 147 ++++++++++++++
 tb/tb_sreg_target.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared types and constants for the pixel configuration shift-register interface
// (responder-side state machine, controller opcodes, chain lengths).
package sreg_pkg;

  localparam int CFG_LEN_FULL    = 84;
  localparam int CFG_LEN_PCLK    = 20;
  localparam int RD_LEN          = 42;
  localparam int READ_END_LEN    = 6;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } sreg_tgt_state_t;

  typedef enum logic [2:0] {
    OP_NOP               = 3'd0,
    OP_WRITE_FULL_PCLK_0 = 3'd1,
    OP_WRITE_FULL_PCLK_1 = 3'd2,
    OP_WRITE_PCLK        = 3'd3,
    OP_PIX_WRITE         = 3'd4,
    OP_READ              = 3'd5,
    OP_READ_END          = 3'd6
  } sreg_op_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    if (v == 7'd127) begin
      return v;
    end else begin
      return v + 7'd1;
    end
  endfunction

endpackage

// File: rtl/sreg_sync.sv
// Multi-flop synchroniser for one asynchronous interface pin, followed by an
// edge-detect flop; the reset value is chosen per pin so idle levels give no edge.
module sreg_sync
  import sreg_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic level_d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              edge_r;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
      edge_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      edge_r <= sync_r[STAGES-1];
    end
  end

  assign level   = sync_r[STAGES-1];
  assign level_d = edge_r;
  assign rise    = sync_r[STAGES-1] & ~edge_r;
  assign fall    = ~sync_r[STAGES-1] & edge_r;

endmodule

// File: rtl/sreg_target.sv
// IC-side responder for the configuration shift-register interface: captures
// serial config into a shadow, commits it on write_cfg, shifts two readback chains.
module sreg_target #(
  parameter int CFG_LEN     = sreg_pkg::CFG_LEN_FULL,
  parameter int RD_LEN      = sreg_pkg::RD_LEN,
  parameter int SYNC_STAGES = sreg_pkg::SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               shift,
  input  logic               serial_in,
  input  logic               write_cfg,
  input  logic [RD_LEN-1:0]  rd_data0,
  input  logic [RD_LEN-1:0]  rd_data1,
  output logic [1:0]         sreg_out,
  output logic [CFG_LEN-1:0] cfg_data,
  output logic [6:0]         cfg_bits,
  output logic               cfg_valid,
  output logic               cfg_ovf
);
  import sreg_pkg::*;

  localparam logic [6:0] CFG_LEN_C = 7'(CFG_LEN);

  logic sclk_rise_s, sclk_fall_s;
  logic shift_lvl_s, shift_prev_s, shift_rise_s, shift_fall_s;
  logic serial_s, write_rise_s;
  // Synchroniser outputs this block has no use for.
  logic [7:0] edge_unused_s;

  sreg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .level(edge_unused_s[0]), .level_d(edge_unused_s[1]),
    .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  sreg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_shift (
    .clk(clk), .rst(rst), .d(shift),
    .level(shift_lvl_s), .level_d(shift_prev_s),
    .rise(shift_rise_s), .fall(shift_fall_s)
  );

  sreg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_serial (
    .clk(clk), .rst(rst), .d(serial_in),
    .level(serial_s), .level_d(edge_unused_s[2]),
    .rise(edge_unused_s[3]), .fall(edge_unused_s[4])
  );

  sreg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_write (
    .clk(clk), .rst(rst), .d(write_cfg),
    .level(edge_unused_s[5]), .level_d(edge_unused_s[6]),
    .rise(write_rise_s), .fall(edge_unused_s[7])
  );

  sreg_tgt_state_t    state_r;
  logic [CFG_LEN-1:0] shadow_r;
  logic [RD_LEN-1:0]  rd_chain0_r, rd_chain1_r;
  logic [6:0]         bit_cnt_r;
  logic [6:0]         cnt_inc_s;
  logic               capture_s, chain_shift_s;
  logic [1:0]         sreg_out_r;
  logic [CFG_LEN-1:0] cfg_data_r;
  logic [6:0]         cfg_bits_r;
  logic               cfg_valid_r, cfg_ovf_r;

  // Gating uses the pre-fall shift level so a bit landing with the shift fall still counts.
  assign cnt_inc_s     = sat_inc7(bit_cnt_r);
  assign capture_s     = sclk_rise_s & shift_prev_s;
  assign chain_shift_s = sclk_fall_s & shift_prev_s;

  // Protocol FSM, shadow/readback datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shadow_r    <= {CFG_LEN{1'b0}};
      rd_chain0_r <= {RD_LEN{1'b0}};
      rd_chain1_r <= {RD_LEN{1'b0}};
      bit_cnt_r   <= 7'd0;
      sreg_out_r  <= 2'b00;
      cfg_data_r  <= {CFG_LEN{1'b0}};
      cfg_bits_r  <= 7'd0;
      cfg_valid_r <= 1'b0;
      cfg_ovf_r   <= 1'b0;
    end else begin
      cfg_valid_r <= 1'b0;
      sreg_out_r  <= {rd_chain1_r[RD_LEN-1], rd_chain0_r[RD_LEN-1]};
      case (state_r)
        ST_IDLE: begin
          if (write_rise_s) begin
            state_r <= ST_COMMIT;
          end else if (shift_rise_s) begin
            state_r     <= ST_SHIFT;
            rd_chain0_r <= rd_data0;
            rd_chain1_r <= rd_data1;
            // An overflowed count keeps accumulating until a commit resolves it.
            if (!cfg_ovf_r) begin
              bit_cnt_r <= 7'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (capture_s) begin
            shadow_r  <= {shadow_r[CFG_LEN-2:0], serial_s};
            bit_cnt_r <= cnt_inc_s;
            if (cnt_inc_s > CFG_LEN_C) begin
              cfg_ovf_r <= 1'b1;
            end
          end
          if (chain_shift_s) begin
            rd_chain0_r <= {rd_chain0_r[RD_LEN-2:0], 1'b0};
            rd_chain1_r <= {rd_chain1_r[RD_LEN-2:0], 1'b0};
          end
          if (write_rise_s) begin
            state_r <= ST_COMMIT;
          end else if (shift_fall_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_COMMIT: begin
          cfg_data_r  <= shadow_r;
          cfg_bits_r  <= bit_cnt_r;
          cfg_valid_r <= 1'b1;
          bit_cnt_r   <= 7'd0;
          if (bit_cnt_r <= CFG_LEN_C) begin
            cfg_ovf_r <= 1'b0;
          end
          state_r <= shift_lvl_s ? ST_SHIFT : ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sreg_out  = sreg_out_r;
  assign cfg_data  = cfg_data_r;
  assign cfg_bits  = cfg_bits_r;
  assign cfg_valid = cfg_valid_r;
  assign cfg_ovf   = cfg_ovf_r;

endmodule

// File: tb/tb_sreg_target.sv
// Directed bench for sreg_target: table of config writes with hand-computed
// results, plus readback, reset-mid-shift and simultaneous-edge sequences.
module tb_sreg_target;

  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        shift = 1'b0;
  logic        serial_in = 1'b0;
  logic        write_cfg = 1'b0;
  logic [41:0] rd_data0 = 42'd0;
  logic [41:0] rd_data1 = 42'd0;
  logic [1:0]  sreg_out;
  logic [83:0] cfg_data;
  logic [6:0]  cfg_bits;
  logic        cfg_valid;
  logic        cfg_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_total = 0;

  sreg_target dut (
    .clk(clk), .rst(rst), .sclk(sclk), .shift(shift), .serial_in(serial_in),
    .write_cfg(write_cfg), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .sreg_out(sreg_out), .cfg_data(cfg_data), .cfg_bits(cfg_bits),
    .cfg_valid(cfg_valid), .cfg_ovf(cfg_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_valid === 1'b1) valid_total++;
  end

  typedef struct {
    int          nbits;
    logic [95:0] data;
    int          mode;   // 0: commit while shifting, 1: commit on last sclk rise, 2: commit from idle
    logic [83:0] exp_data;
    logic [6:0]  exp_bits;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input string name, input int nbits, input logic [95:0] data,
                          input int mode, input logic [83:0] exp_data,
                          input logic [6:0] exp_bits, input logic exp_ovf);
    int v0;
    v0 = valid_total;
    shift = 1'b1;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      serial_in = data[nbits-1-i];
      tick(HP);
      sclk = 1'b1;
      if (mode == 1 && i == nbits - 1) write_cfg = 1'b1;
      tick(HP);
    end
    if (mode == 1) begin
      tick(4);
      write_cfg = 1'b0;
      tick(8);
    end else if (mode == 2) begin
      shift = 1'b0;
      tick(8);
      write_cfg = 1'b1;
      tick(HP);
      write_cfg = 1'b0;
      tick(10);
    end else begin
      write_cfg = 1'b1;
      tick(HP);
      write_cfg = 1'b0;
      tick(10);
    end
    shift = 1'b0;
    tick(8);
    check({name, "_valid_count"}, 96'(valid_total - v0), 96'd1);
    check({name, "_cfg_data"}, 96'(cfg_data), 96'(exp_data));
    check({name, "_cfg_bits"}, 96'(cfg_bits), 96'(exp_bits));
    check({name, "_cfg_ovf"}, 96'(cfg_ovf), 96'(exp_ovf));
  endtask

  initial begin
    logic [41:0] rd0;
    logic [41:0] rd1;
    int v0;

    vecs[0] = '{84, {12'd0, 84'hA5A5A5A5A5A5A5A5A5A5A}, 0, 84'hA5A5A5A5A5A5A5A5A5A5A, 7'd84, 1'b0};
    vecs[1] = '{20, {76'd0, 20'hF0F0F}, 0, 84'h5A5A5A5A5A5A5A5AF0F0F, 7'd20, 1'b0};
    vecs[2] = '{90, {6'd0, 6'b110011, 84'hFEDCBA9876543210FEDCB}, 0, 84'hFEDCBA9876543210FEDCB, 7'd90, 1'b1};
    vecs[3] = '{84, {12'd0, 84'h123456789ABCDEF012345}, 0, 84'h123456789ABCDEF012345, 7'd84, 1'b0};
    vecs[4] = '{8, {88'd0, 8'h3C}, 0, 84'h3456789ABCDEF0123453C, 7'd8, 1'b0};
    vecs[5] = '{85, {11'd0, 1'b1, 84'h0F0F0F0F0F0F0F0F0F0F0}, 0, 84'h0F0F0F0F0F0F0F0F0F0F0, 7'd85, 1'b1};
    vecs[6] = '{84, {12'd0, 84'h000000000000000000001}, 0, 84'h000000000000000000001, 7'd84, 1'b0};
    vecs[7] = '{12, {84'd0, 12'hABC}, 2, 84'h000000000000000001ABC, 7'd12, 1'b0};

    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_cfg_data", 96'(cfg_data), 96'd0);
    check("rst_cfg_bits", 96'(cfg_bits), 96'd0);
    check("rst_cfg_valid", 96'(cfg_valid), 96'd0);
    check("rst_cfg_ovf", 96'(cfg_ovf), 96'd0);
    check("rst_sreg_out", 96'(sreg_out), 96'd0);
    tick(4);

    for (int k = 0; k < 8; k++) begin
      do_write($sformatf("vec%0d", k), vecs[k].nbits, vecs[k].data, vecs[k].mode,
               vecs[k].exp_data, vecs[k].exp_bits, vecs[k].exp_ovf);
    end

    // Readback chains, MSB first, zero fill afterwards
    rd0 = 42'h2AAAAAAAAAA;
    rd1 = ~rd0;
    rd_data0 = rd0;
    rd_data1 = rd1;
    serial_in = 1'b0;
    shift = 1'b1;
    tick(8);
    for (int j = 0; j < 42; j++) begin
      check($sformatf("rd0_bit%0d", 41 - j), 96'(sreg_out[0]), 96'(rd0[41-j]));
      check($sformatf("rd1_bit%0d", 41 - j), 96'(sreg_out[1]), 96'(rd1[41-j]));
      sclk = 1'b0;
      tick(HP);
      sclk = 1'b1;
      tick(HP);
    end
    check("rd_zero_fill", 96'(sreg_out), 96'd0);
    shift = 1'b0;
    tick(8);

    // Reset in the middle of a write
    shift = 1'b1;
    tick(8);
    for (int i = 0; i < 30; i++) begin
      sclk = 1'b0;
      serial_in = i[0];
      tick(HP);
      sclk = 1'b1;
      tick(HP);
    end
    rst = 1'b1;
    shift = 1'b0;
    tick(1);
    rst = 1'b0;
    check("midrst_cfg_data", 96'(cfg_data), 96'd0);
    check("midrst_cfg_bits", 96'(cfg_bits), 96'd0);
    check("midrst_cfg_valid", 96'(cfg_valid), 96'd0);
    check("midrst_cfg_ovf", 96'(cfg_ovf), 96'd0);
    check("midrst_sreg_out", 96'(sreg_out), 96'd0);
    v0 = valid_total;
    tick(12);
    check("midrst_no_valid", 96'(valid_total - v0), 96'd0);
    do_write("post_rst", 84, {12'd0, 84'h0123456789ABCDEF01234}, 0,
             84'h0123456789ABCDEF01234, 7'd84, 1'b0);

    // write_cfg rising with the 84th sclk rise and then held high
    do_write("simult_hold", 84, {12'd0, 84'hC3C3C3C3C3C3C3C3C3C3C}, 1,
             84'hC3C3C3C3C3C3C3C3C3C3C, 7'd84, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
